// File: rtl/multicore_pkg.sv
// multicore_pkg: shared decode types and system-unit constants
package multicore_pkg;
  typedef enum logic [2:0] {
    RDCYCLE, RDCYCLEH, RDTIME, RDTIMEH, RDINSTRET, RDINSTRETH, SCALL, SBREAK
  } t_sysop;
  typedef enum logic {SYS_IDLE, SYS_TRAP_WAIT} t_sys_state;
  localparam logic TRAP_CAUSE_SCALL  = 1'b0;
  localparam logic TRAP_CAUSE_SBREAK = 1'b1;
endpackage

// File: rtl/system_unit_counter64.sv
// counter64: 64-bit wrapping counter with increment enable
module counter64 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inc,
  output logic [63:0] o_count
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_count <= '0;
    else if (i_inc) o_count <= o_count + 64'd1;
endmodule

// File: rtl/system_unit.sv
// system_unit: cycle/time/instret counter reads and SCALL/SBREAK trap request
module system_unit
  import multicore_pkg::*;
#(
  parameter int TIME_DIV = 1,
  parameter int XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  t_sysop          i_sysop,
  input  logic            i_retire,
  input  logic            i_trap_ack,
  output logic [XLEN-1:0] o_result,
  output logic            o_result_valid,
  output logic            o_trap_req,
  output logic            o_trap_cause,
  output logic            o_busy
);
  t_sys_state      state;
  logic [15:0]     pre;
  logic            time_tick;
  logic            is_trap;
  logic            hi;
  logic [63:0]     cycle_q, time_q, instret_q, sel;
  logic [XLEN-1:0] word;
  assign time_tick = pre == 16'(TIME_DIV - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) pre <= '0;
    else pre <= time_tick ? '0 : pre + 16'd1;
  counter64 u_cycle   (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(1'b1),      .o_count(cycle_q));
  counter64 u_time    (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(time_tick), .o_count(time_q));
  counter64 u_instret (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(i_retire),  .o_count(instret_q));
  // anything not a time/instret read falls back to cycle, matching decode
  always_comb begin
    is_trap = i_sysop == SCALL || i_sysop == SBREAK;
    hi      = i_sysop == RDCYCLEH || i_sysop == RDTIMEH || i_sysop == RDINSTRETH;
    sel     = (i_sysop == RDTIME || i_sysop == RDTIMEH) ? time_q :
              (i_sysop == RDINSTRET || i_sysop == RDINSTRETH) ? instret_q : cycle_q;
    word    = hi ? sel[63:32] : sel[31:0];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state          <= SYS_IDLE;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_trap_req     <= 1'b0;
      o_trap_cause   <= TRAP_CAUSE_SCALL;
      o_busy         <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      if (state == SYS_IDLE) begin
        if (i_en && is_trap) begin
          state        <= SYS_TRAP_WAIT;
          o_trap_req   <= 1'b1;
          o_busy       <= 1'b1;
          o_trap_cause <= (i_sysop == SBREAK) ? TRAP_CAUSE_SBREAK : TRAP_CAUSE_SCALL;
        end else if (i_en) begin
          o_result       <= word;
          o_result_valid <= 1'b1;
        end
      end else if (i_trap_ack) begin
        state      <= SYS_IDLE;
        o_trap_req <= 1'b0;
        o_busy     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_system_unit.sv
// tb_system_unit: directed checks of counter reads and the trap handshake
module tb_system_unit;
  import multicore_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n, en, retire, ack;
  t_sysop      sysop;
  logic [31:0] res, res4;
  logic        vld, vld4, req, req4, cause, cause4, busy, busy4;
  int          n_pass = 0;
  int          n_total = 0;
  always #5 clk = ~clk;
  system_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sysop(sysop), .i_retire(retire),
    .i_trap_ack(ack), .o_result(res), .o_result_valid(vld), .o_trap_req(req),
    .o_trap_cause(cause), .o_busy(busy)
  );
  system_unit #(.TIME_DIV(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sysop(sysop), .i_retire(retire),
    .i_trap_ack(ack), .o_result(res4), .o_result_valid(vld4), .o_trap_req(req4),
    .o_trap_cause(cause4), .o_busy(busy4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; sysop = RDCYCLE; retire = 1'b0; ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_result", res, 0);
    check("rst_valid", vld, 0);
    check("rst_req", req, 0);
    check("rst_cause", cause, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (9) tick;
    en = 1'b1; sysop = RDCYCLE;
    tick;
    en = 1'b0;
    check("rdcycle_e10", res, 9);
    check("rdcycle_valid", vld, 1);
    tick;
    check("valid_pulse", vld, 0);
    check("result_hold", res, 9);
    repeat (9) tick;
    en = 1'b1; sysop = RDTIME;
    tick;
    check("rdtime_div1", res, 20);
    check("rdtime_div4", res4, 5);
    sysop = RDCYCLE;
    tick;
    check("b2b_first", res, 21);
    check("b2b_first_v", vld, 1);
    tick;
    check("b2b_second", res, 22);
    check("b2b_second_v", vld, 1);
    en = 1'b0;
    force dut.u_instret.o_count = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_instret.o_count;
    retire = 1'b1; en = 1'b1; sysop = RDINSTRET;
    tick;
    retire = 1'b0;
    check("instret_pre", res, 32'hFFFF_FFFF);
    sysop = RDINSTRETH;
    tick;
    check("instreth_carry", res, 1);
    sysop = RDINSTRET;
    tick;
    check("instret_wrap", res, 0);
    en = 1'b0;
    force dut.u_cycle.o_count = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_cycle.o_count;
    en = 1'b1; sysop = RDCYCLEH;
    tick;
    check("cycleh_before", res, 0);
    tick;
    check("cycleh_after", res, 1);
    sysop = RDCYCLE;
    tick;
    check("cycle_low", res, 1);
    sysop = SBREAK;
    tick;
    check("sbreak_req", req, 1);
    check("sbreak_cause", cause, 1);
    check("sbreak_busy", busy, 1);
    check("sbreak_novalid", vld, 0);
    sysop = RDCYCLE;
    tick;
    en = 1'b0;
    check("wait_read_novalid", vld, 0);
    check("wait_res_hold", res, 1);
    tick;
    tick;
    check("wait_req_held", req, 1);
    check("wait_busy_held", busy, 1);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("ack_req_clear", req, 0);
    check("ack_busy_clear", busy, 0);
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("idle_ack_ignored", req, 0);
    en = 1'b1; sysop = SCALL;
    tick;
    check("scall_req", req, 1);
    check("scall_cause", cause, 0);
    ack = 1'b1; en = 1'b0;
    tick;
    ack = 1'b0;
    check("scall_ack", req, 0);
    en = 1'b1; sysop = SBREAK;
    tick;
    en = 1'b0;
    check("pre_rst_req", req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", req, 0);
    check("arst_busy", busy, 0);
    check("arst_cause", cause, 0);
    check("arst_result", res, 0);
    check("arst_valid", vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; sysop = RDCYCLE;
    tick;
    check("post_rst_cycle", res, 0);
    check("post_rst_valid", vld, 1);
    check("post_rst_busy", busy, 0);
    tick;
    en = 1'b0;
    check("post_rst_cycle2", res, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
